// File: rtl/usb_piso_stream_if.sv
// Payload word stream into the USB transmit serializer: word, end-of-packet flag,
// and a valid/ready handshake.
interface usb_piso_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_last, output s_valid, input s_ready);
  modport slave  (input s_data, input s_last, input s_valid, output s_ready);
endinterface

// File: rtl/usb_piso_stream.sv
// USB hub transmit serializer: queued payload words plus injected SYNC/PID/ACK bytes, shifted LSB first.
// Optional bit stuffing is enabled by defining USB_PISO_BIT_STUFF_EN.
module usb_piso_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  usb_piso_stream_if.slave s,
  input  logic             request_serial_data,
  input  logic [1:0]       request_serial_data_type,
  input  logic [3:0]       pid_in,
  output logic             ctrl_busy,
  output logic             piso_data_out,
  output logic             piso_data_val,
  output logic             piso_data_last,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [7:0] ctrl_encode(input logic [1:0] typ, input logic [3:0] pid);
    case (typ)
      2'd1:    ctrl_encode = 8'h80;
      2'd2:    ctrl_encode = {~pid, pid};
      default: ctrl_encode = 8'hD2;
    endcase
  endfunction

  state_t                state;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  ctrl_full;
  logic                  ctrl_last;
  logic [7:0]            ctrl_byte;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         cur_len;
  logic                  cur_last;
  logic                  out_bit;
  logic                  out_val;
  logic                  out_last;
  logic                  push;
  logic                  pop;
  logic                  adv;
  logic                  load_ctrl;
  logic                  final_bit;
  logic                  stall;

`ifdef USB_PISO_BIT_STUFF_EN
  logic [2:0] ones;
  logic       stuff_pend;
  logic       stuff_last;
  logic       emit_last;
  assign stall     = stuff_pend;
  assign emit_last = final_bit && cur_last;
`else
  assign stall = 1'b0;
`endif

  assign s.s_ready      = (level != LVL_W'(DEPTH));
  assign ctrl_busy      = ctrl_full;
  assign fifo_level     = level;
  assign piso_data_out  = out_bit;
  assign piso_data_val  = out_val;
  assign piso_data_last = out_last;

  // The next source is taken from IDLE or on the final bit of the current entry; control wins.
  assign push      = s.s_valid && s.s_ready;
  assign final_bit = (state == SHIFT) && (bit_cnt == cur_len - CW'(1));
  assign adv       = !stall && ((state == IDLE) || final_bit);
  assign load_ctrl = adv && ctrl_full;
  assign pop       = adv && !ctrl_full && (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s.s_last, s.s_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_full <= 1'b0;
    end else if (load_ctrl) begin
      ctrl_full <= 1'b0;
    end else if (request_serial_data && !ctrl_full && (request_serial_data_type != 2'd0)) begin
      ctrl_full <= 1'b1;
      ctrl_byte <= ctrl_encode(request_serial_data_type, pid_in);
      ctrl_last <= (request_serial_data_type == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      bit_cnt  <= '0;
      out_bit  <= 1'b0;
      out_val  <= 1'b0;
      out_last <= 1'b0;
`ifdef USB_PISO_BIT_STUFF_EN
      ones       <= 3'd0;
      stuff_pend <= 1'b0;
      stuff_last <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      out_bit  <= 1'b0;
      out_val  <= 1'b0;
      out_last <= 1'b0;

`ifdef USB_PISO_BIT_STUFF_EN
      // Stuffed zero: everything else holds for this cycle.
      if (stuff_pend) begin
        out_val    <= 1'b1;
        out_last   <= stuff_last;
        stuff_pend <= 1'b0;
        ones       <= 3'd0;
      end else
`endif
      if (state == SHIFT) begin
        out_bit <= shift[0];
        out_val <= 1'b1;
`ifdef USB_PISO_BIT_STUFF_EN
        if (shift[0] && (ones == 3'd5)) begin
          stuff_pend <= 1'b1;
          stuff_last <= emit_last;
          ones       <= 3'd0;
        end else begin
          out_last <= emit_last;
          ones     <= shift[0] ? ones + 3'd1 : 3'd0;
        end
`else
        out_last <= final_bit && cur_last;
`endif
        if (!final_bit) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
`ifdef USB_PISO_BIT_STUFF_EN
      else begin
        ones <= 3'd0;
      end
`endif

      if (load_ctrl) begin
        shift    <= DATA_WIDTH'(ctrl_byte);
        cur_len  <= CW'(8);
        cur_last <= ctrl_last;
        bit_cnt  <= '0;
        state    <= SHIFT;
      end else if (pop) begin
        {cur_last, shift} <= mem[rd_ptr];
        cur_len  <= CW'(DATA_WIDTH);
        bit_cnt  <= '0;
        state    <= SHIFT;
      end else if (adv) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_usb_piso_stream.sv
// Scoreboard bench for usb_piso_stream: expected serial bits are queued as stimulus is issued
// and a negedge monitor pops and compares every valid output bit.
module tb_usb_piso_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       request_serial_data = 1'b0;
  logic [1:0] request_serial_data_type = 2'd0;
  logic [3:0] pid_in = 4'h0;
  logic       ctrl_busy;
  logic       piso_data_out;
  logic       piso_data_val;
  logic       piso_data_last;
  logic [2:0] fifo_level;

  usb_piso_stream_if #(.DATA_WIDTH(8)) sif ();

  usb_piso_stream #(.DATA_WIDTH(8), .DEPTH(4), .LVL_W(3)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s                        (sif),
    .request_serial_data      (request_serial_data),
    .request_serial_data_type (request_serial_data_type),
    .pid_in                   (pid_in),
    .ctrl_busy                (ctrl_busy),
    .piso_data_out            (piso_data_out),
    .piso_data_val            (piso_data_val),
    .piso_data_last           (piso_data_last),
    .fifo_level               (fifo_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run_len = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: entries are {last, bit}.
  always @(negedge clk) begin
    if (piso_data_val === 1'b1) begin
      run_len++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_bit: got bit=%0b last=%0b, expected no output", piso_data_out, piso_data_last);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({piso_data_last, piso_data_out} !== e) begin
          miscompares++;
          $display("FAIL serial_bit: got last=%0b bit=%0b, expected last=%0b bit=%0b",
                   piso_data_last, piso_data_out, e[1], e[0]);
        end
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  task automatic exp_word(input logic [7:0] b, input logic l);
    for (int i = 0; i < 8; i++) exp_q.push_back({l && (i == 7), b[i]});
  endtask

  task automatic push(input logic [7:0] d, input logic l, output int t);
    logic r;
    sif.s_data  = d;
    sif.s_last  = l;
    sif.s_valid = 1'b1;
    t = -1;
    for (int n = 0; n < 200; n++) begin
      r = sif.s_ready;
      @(posedge clk);
      #1;
      if (r) begin
        t = cyc;
        break;
      end
    end
    sif.s_valid = 1'b0;
    if (t < 0) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic request(input logic [1:0] typ, input logic [3:0] pid, output int t);
    request_serial_data      = 1'b1;
    request_serial_data_type = typ;
    pid_in                   = pid;
    @(posedge clk);
    #1;
    t = cyc;
    request_serial_data = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && piso_data_val === 1'b0) begin
        done = 1;
        break;
      end
    end
    @(negedge clk);
    chk({name, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int t0, t1, tr, td;
    sif.s_data  = 8'h00;
    sif.s_last  = 1'b0;
    sif.s_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_val", {31'd0, piso_data_val}, 32'd0);
    chk("rst_last", {31'd0, piso_data_last}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_ready", {31'd0, sif.s_ready}, 32'd1);
    chk("rst_busy", {31'd0, ctrl_busy}, 32'd0);

    // Single word A5 with last, latency 2
    exp_word(8'hA5, 1'b1);
    push(8'hA5, 1'b1, t0);
    @(negedge clk);
    chk("a5_level_after_push", {29'd0, fifo_level}, 32'd1);
    chk("a5_val_t0", {31'd0, piso_data_val}, 32'd0);
    @(negedge clk);
    chk("a5_val_t1", {31'd0, piso_data_val}, 32'd0);
    @(negedge clk);
    chk("a5_val_t2", {31'd0, piso_data_val}, 32'd1);
    wait_drain("a5");
    chk("a5_run", last_run, 32'd8);
    chk("a5_level_end", {29'd0, fifo_level}, 32'd0);

    // SYNC then 3C, C3(last): 24 contiguous bits
    exp_word(8'h80, 1'b0);
    exp_word(8'h3C, 1'b0);
    exp_word(8'hC3, 1'b1);
    request(2'd1, 4'h0, tr);
    push(8'h3C, 1'b0, t0);
    push(8'hC3, 1'b1, t1);
    wait_drain("sync");
    chk("sync_run", last_run, 32'd24);

    // Queue fills behind a SYNC byte; fifth word waits for the first pop
    exp_word(8'h80, 1'b0);
    exp_word(8'h11, 1'b0);
    exp_word(8'h22, 1'b0);
    exp_word(8'h33, 1'b0);
    exp_word(8'h44, 1'b0);
    exp_word(8'h55, 1'b1);
    request(2'd1, 4'h0, tr);
    push(8'h11, 1'b0, t0);
    push(8'h22, 1'b0, t0);
    push(8'h33, 1'b0, t0);
    push(8'h44, 1'b0, t0);
    @(negedge clk);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, sif.s_ready}, 32'd0);
    push(8'h55, 1'b1, t1);
    chk("full_accept_cycle", t1 - tr, 32'd10);
    wait_drain("full");
    chk("full_run", last_run, 32'd48);
    chk("full_level_end", {29'd0, fifo_level}, 32'd0);

    // PID mid-word goes right after it; ACK while busy is dropped
    exp_word(8'h5A, 1'b0);
    exp_word(8'hE1, 1'b0);
    exp_word(8'h81, 1'b1);
    push(8'h5A, 1'b0, t0);
    @(posedge clk);
    #1;
    request(2'd2, 4'h1, tr);
    chk("pid_busy", {31'd0, ctrl_busy}, 32'd1);
    request(2'd3, 4'h0, td);
    chk("pid_busy_after_drop", {31'd0, ctrl_busy}, 32'd1);
    push(8'h81, 1'b1, t1);
    wait_drain("pid");
    chk("pid_run", last_run, 32'd24);
    chk("pid_busy_end", {31'd0, ctrl_busy}, 32'd0);

    // All-ones word
`ifdef USB_PISO_BIT_STUFF_EN
    for (int i = 0; i < 6; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    push(8'hFF, 1'b1, t0);
    wait_drain("ff");
    chk("ff_run", last_run, 32'd9);
`else
    exp_word(8'hFF, 1'b1);
    push(8'hFF, 1'b1, t0);
    wait_drain("ff");
    chk("ff_run", last_run, 32'd8);
`endif

    // Reset during the 4th bit of 36 with two words queued behind it
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h36 >> i} & 2'b01);
    push(8'h36, 1'b0, t0);
    push(8'h11, 1'b0, t1);
    push(8'h22, 1'b1, t1);
    for (int n = 0; n < 20 && cyc < t0 + 5; n++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_mid_level", {29'd0, fifo_level}, 32'd2);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_val", {31'd0, piso_data_val}, 32'd0);
    chk("rst_mid_level0", {29'd0, fifo_level}, 32'd0);
    chk("rst_mid_ready", {31'd0, sif.s_ready}, 32'd1);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_leftover", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_piso_stream.md
# usb_piso_stream

Parametrised parallel-in/serial-out transmit serializer for the USB hub transmit path, placed between the transmit word FIFO logic and the NRZI encoder. It accepts packet words through a valid/ready handshake into a DEPTH-entry holding queue. It injects SYNC, PID and ACK control bytes on request from the transaction logic. It then shifts every word out LSB first with no idle bit between back-to-back words, and marks the final bit of each packet.

## Interface
- DATA_WIDTH, 8: payload word width in bits; must be ≥ 8.
- DEPTH, 4: holding-queue entries; power of two, ≥ 2.
- LVL_W, $clog2(DEPTH+1): width of fifo_level.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- s_data  in  DATA_WIDTH  payload word.
- s_last  in  1  word is the last of its packet.
- s_valid  in  1  s_data/s_last valid.
- s_ready  out  1  queue can accept a word this cycle.
- request_serial_data  in  1  one-cycle pulse requesting a control byte.
- request_serial_data_type  in  2  0 NULL, 1 SYNC, 2 PID, 3 ACK.
- pid_in  in  4  PID nibble used when the type is PID.
- ctrl_busy  out  1  control slot occupied; new requests are ignored.
- piso_data_out  out  1  serial bit.
- piso_data_val  out  1  piso_data_out is valid this cycle.
- piso_data_last  out  1  final bit of a packet, qualified by piso_data_val.
- fifo_level  out  LVL_W  number of occupied queue entries.

## Operation
- Queue: circular buffer of DEPTH entries, each {last, data}. A push occurs on s_valid && s_ready. s_ready = (fifo_level != DEPTH). Pointers wrap modulo DEPTH.
- Control slot: single entry of {len=8, last, byte}. It loads on request_serial_data when empty.
  - SYNC = 8'h80, last = 0.
  - PID = {~pid_in, pid_in}, last = 0.
  - ACK = 8'hD2, last = 1.
  - NULL, or any request while ctrl_busy = 1, is ignored with no state change.
- Shifter FSM:
  - IDLE: if the control slot is full, load it. Otherwise, if the queue is non-empty, pop and load the head with len = DATA_WIDTH. Then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: emit shift[0], shift right, increment bit_cnt.
    - On the final bit (bit_cnt == len-1), load the next source in the same cycle, using the same priority (control before queue). Stay in SHIFT if a source exists; otherwise go to IDLE.
    - The control slot is therefore only taken at word boundaries and never splits a word.
- piso_data_last = 1 on the final bit of an entry whose last flag = 1; 0 otherwise.
- A queue push and pop in the same cycle leaves fifo_level unchanged. A push into a full queue cannot occur because s_ready = 0.
- Reset (rst = 0 at a clock edge), including mid-word: pointers, level, control slot, FSM (→ IDLE), bit_cnt, and the stuffing counter all clear. All outputs become 0, except s_ready = 1. A partially sent word is discarded.

## Timing
- All outputs are registered except s_ready and ctrl_busy, which are decoded from registered state.
- Latency: a word pushed at edge T into an empty queue with the shifter in IDLE produces its first bit with piso_data_val = 1 in the cycle after edge T+2.
- Control request at edge T with the shifter in IDLE: first bit in the cycle after edge T+2.
- Back-to-back entries: piso_data_val stays continuously high across word boundaries.
- Throughput: one bit per clock; a DATA_WIDTH word drains in DATA_WIDTH cycles (not counting stuff bits).

## Configuration
- USB_PISO_BIT_STUFF_EN defined:
  - After six consecutive emitted 1 bits, the next valid cycle emits a stuffed 0 with piso_data_val = 1. The shifter and bit_cnt hold during that cycle, and the ones counter clears.
  - If the sixth 1 was the packet's final bit, piso_data_last moves to the stuffed 0.
  - The ones counter clears whenever piso_data_val = 0 and on reset.
- USB_PISO_BIT_STUFF_EN undefined: no stuffing logic; the output stream is exactly the shifted data.

## Test plan
- Reset, then push 8'hA5 with s_last = 1 → after a 2-cycle latency, 8 valid bits 1,0,1,0,0,1,0,1; piso_data_last on the 8th bit; fifo_level returns to 0.
- SYNC request, then push 8'h3C, 8'hC3 (last on the second) → 24 contiguous valid bits, SYNC first (0000_0001); piso_data_last only on bit 24.
- Push 5 words with DEPTH = 4 while the shifter is stalled on a control byte → s_ready = 0 at fifo_level = 4; the 5th word is accepted one cycle after the first pop; order is preserved.
- PID request with pid_in = 4'h1 while a word is mid-shift → byte 8'hE1 is sent directly after the current word's final bit; a second request while ctrl_busy = 1 is dropped.
- Stuffing enabled, push 8'hFF with last → bits 1×6, stuffed 0, 1,1, then piso_data_last on the 9th valid bit. With stuffing disabled, the same stimulus gives 8 bits with last on bit 8.
- rst = 0 in the 4th bit of a word with 2 entries queued → the next cycle has piso_data_val = 0, fifo_level = 0, s_ready = 1; no residual bits appear after reset is released.
